// File: rtl/gpu_pkg.sv
// Shared GPU constants and types for the rect table fetcher.
package gpu_pkg;

    localparam int RECT_COUNT     = 64;
    localparam int WORDS_PER_RECT = 5;
    localparam int ADDR_WIDTH     = 13;
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = 13'h1EC0;

    // Word order of one rect record in data memory.
    typedef enum logic [2:0] {
        F_X,
        F_Y,
        F_W,
        F_H,
        F_COLOR
    } rect_field_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } fetch_state_t;

endpackage

// File: rtl/rect_fetcher.sv
// Per-frame copy of the rect table from shared data memory into the back
// bank of the GPU rect register file, finished by a bank-swap commit pulse.
//
//  state  | meaning
//  IDLE   | waiting for the vblank start pulse
//  FETCH  | requesting table words from the arbiter, one per grant
//  DRAIN  | last word in flight, written this cycle
//  COMMIT | one-cycle swap pulse, back bank complete
module rect_fetcher #(
    parameter int RECT_COUNT     = gpu_pkg::RECT_COUNT,
    parameter int WORDS_PER_RECT = gpu_pkg::WORDS_PER_RECT,
    parameter int ADDR_WIDTH     = gpu_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = gpu_pkg::BASE_ADDR
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    output logic                              mem_req_o,
    output logic [ADDR_WIDTH-1:0]             mem_addr_o,
    input  logic                              mem_gnt_i,
    input  logic [15:0]                       mem_rdata_i,
    output logic                              rect_we_o,
    output logic [$clog2(RECT_COUNT)-1:0]     rect_idx_o,
    output logic [$clog2(WORDS_PER_RECT)-1:0] rect_field_o,
    output logic [15:0]                       rect_data_o,
    output logic                              busy_o,
    output logic                              commit_o
);
    import gpu_pkg::*;

    localparam int N       = RECT_COUNT * WORDS_PER_RECT;
    localparam int RD_W    = $clog2(N + 1);
    localparam int IDX_W   = $clog2(RECT_COUNT);
    localparam int FIELD_W = $clog2(WORDS_PER_RECT);

    // The table must not run past the top of the address space.
    if (int'(BASE_ADDR) + N > (1 << ADDR_WIDTH)) begin : g_bad_table
        $error("rect table at BASE_ADDR overruns the address space");
    end
    if (RECT_COUNT < 2 || WORDS_PER_RECT < 2) begin : g_bad_size
        $error("RECT_COUNT and WORDS_PER_RECT must both be at least 2");
    end

    fetch_state_t           state_q, state_d;
    logic [RD_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FIELD_W-1:0]     field_q, field_d;
    logic                   issued_q, issued_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic                   busy_q, busy_d;
    logic                   commit_q, commit_d;

    // Next-state logic: read sequencing, write-index advance and frame control.
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        idx_d      = idx_q;
        field_d    = field_q;
        issued_d   = 1'b0;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        commit_d   = 1'b0;

        // A word returned this cycle is written now; step to the next slot.
        if (issued_q) begin
            if (field_q == FIELD_W'(WORDS_PER_RECT - 1)) begin
                field_d = '0;
                if (idx_q != IDX_W'(RECT_COUNT - 1)) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                field_d = field_q + FIELD_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = FETCH;
                    rd_cnt_d   = '0;
                    idx_d      = '0;
                    field_d    = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = BASE_ADDR;
                    busy_d     = 1'b1;
                end
            end
            FETCH: begin
                if (mem_req_q && mem_gnt_i) begin
                    issued_d   = 1'b1;
                    rd_cnt_d   = rd_cnt_q + RD_W'(1);
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                    if (rd_cnt_q == RD_W'(N - 1)) begin
                        state_d    = DRAIN;
                        mem_req_d  = 1'b0;
                        mem_addr_d = '0;
                    end
                end
            end
            DRAIN: begin
                state_d  = COMMIT;
                commit_d = 1'b1;
            end
            COMMIT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            idx_q      <= '0;
            field_q    <= '0;
            issued_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            idx_q      <= idx_d;
            field_q    <= field_d;
            issued_q   <= issued_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            commit_q   <= commit_d;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign rect_we_o    = issued_q;
    assign rect_idx_o   = idx_q;
    assign rect_field_o = field_q;
    // Read data lands one cycle after issue, exactly when the write strobe is up.
    assign rect_data_o  = issued_q ? mem_rdata_i : 16'h0000;
    assign busy_o       = busy_q;
    assign commit_o     = commit_q;

endmodule

// File: tb/tb_rect_fetcher.sv
// Scoreboard bench for rect_fetcher: default 64x5 table plus a 2x5 variant.
module tb_rect_fetcher;

    localparam int BASE = 'h1EC0;

    typedef struct {
        int idx;
        int fld;
        int data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, gnt, sel6;
    logic [15:0] mem_rdata;

    logic        req_a, we_a, busy_a, commit_a;
    logic [12:0] addr_a;
    logic [5:0]  idx_a;
    logic [2:0]  field_a;
    logic [15:0] data_a;

    logic        req_b, we_b, busy_b, commit_b;
    logic [12:0] addr_b;
    logic [0:0]  idx_b;
    logic [2:0]  field_b;
    logic [15:0] data_b;

    rect_fetcher dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(start & ~sel6),
        .mem_req_o(req_a), .mem_addr_o(addr_a), .mem_gnt_i(gnt & ~sel6),
        .mem_rdata_i(mem_rdata), .rect_we_o(we_a), .rect_idx_o(idx_a),
        .rect_field_o(field_a), .rect_data_o(data_a), .busy_o(busy_a),
        .commit_o(commit_a)
    );

    rect_fetcher #(.RECT_COUNT(2)) dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(start & sel6),
        .mem_req_o(req_b), .mem_addr_o(addr_b), .mem_gnt_i(gnt & sel6),
        .mem_rdata_i(mem_rdata), .rect_we_o(we_b), .rect_idx_o(idx_b),
        .rect_field_o(field_b), .rect_data_o(data_b), .busy_o(busy_b),
        .commit_o(commit_b)
    );

    logic        m_req, m_we, m_busy, m_commit;
    logic [12:0] m_addr;
    logic [5:0]  m_idx;
    logic [2:0]  m_field;
    logic [15:0] m_data;
    assign m_req    = sel6 ? req_b    : req_a;
    assign m_we     = sel6 ? we_b     : we_a;
    assign m_busy   = sel6 ? busy_b   : busy_a;
    assign m_commit = sel6 ? commit_b : commit_a;
    assign m_addr   = sel6 ? addr_b   : addr_a;
    assign m_idx    = sel6 ? {5'b0, idx_b} : idx_a;
    assign m_field  = sel6 ? field_b  : field_a;
    assign m_data   = sel6 ? data_b   : data_a;

    // Memory: word at BASE+k holds k; data appears one cycle after the issuing cycle.
    always @(posedge clk)
        mem_rdata <= (m_req && gnt) ? ({3'b000, m_addr} - 16'h1EC0) : 16'hDEAD;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int  n_total = 0;
    int  n_pass  = 0;
    int  t0, grants, cur_n, exp_commit, mk;
    bit  frame_active = 1'b0;
    bit  prev_issue;
    wr_t sb[$];
    wr_t mw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Monitor: per-cycle protocol model plus write scoreboard.
    always @(negedge clk) begin
        if (frame_active) begin
            mk = edge_n - t0;
            chk("busy", 32'(m_busy), 32'(mk <= exp_commit));
            chk("mem_req", 32'(m_req), 32'(grants < cur_n));
            if (m_req) chk("mem_addr", 32'(m_addr), 32'(BASE + grants));
            chk("rect_we_after_issue", 32'(m_we), 32'(prev_issue));
            chk("commit", 32'(m_commit), 32'(mk == exp_commit));
            if (mk == 1) chk("first_addr", 32'(m_addr), 32'h1EC0);
            if (m_we) begin
                chk("write_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mw = sb.pop_front();
                    chk("rect_idx", 32'(m_idx), 32'(mw.idx));
                    chk("rect_field", 32'(m_field), 32'(mw.fld));
                    chk("rect_data", 32'(m_data), 32'(mw.data));
                end
            end
            prev_issue = m_req && gnt;
            if (prev_issue) grants++;
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req"},    32'(m_req),    32'd0);
        chk({tag, "_addr"},   32'(m_addr),   32'd0);
        chk({tag, "_we"},     32'(m_we),     32'd0);
        chk({tag, "_idx"},    32'(m_idx),    32'd0);
        chk({tag, "_field"},  32'(m_field),  32'd0);
        chk({tag, "_data"},   32'(m_data),   32'd0);
        chk({tag, "_busy"},   32'(m_busy),   32'd0);
        chk({tag, "_commit"}, 32'(m_commit), 32'd0);
    endtask

    function automatic bit gnt_fn(input int mode, input int k);
        case (mode)
            2:       return (k % 2) == 0;
            3:       return !(k >= 320 && k <= 369);
            default: return 1'b1;
        endcase
    endfunction

    // Runs one frame; called with time #1 after a rising edge.
    // mode: 1 plain, 2 toggling grant, 3 long stall on last word,
    //       4 extra start pulses, 5 reset in cycle 100.
    task automatic run_frame(input int mode, input int n, input int exp_c);
        wr_t w;
        sb.delete();
        for (int j = 0; j < n; j++) begin
            w.idx = j / 5; w.fld = j % 5; w.data = j;
            sb.push_back(w);
        end
        grants = 0; prev_issue = 1'b0; cur_n = n; exp_commit = exp_c;
        start = 1'b1; gnt = 1'b1;
        @(posedge clk); #1;
        t0 = edge_n - 1; start = 1'b0; frame_active = 1'b1;
        for (int k = 1; k <= exp_c + 2; k++) begin
            gnt   = gnt_fn(mode, k);
            start = (mode == 4) && (k == 10 || k == 322);
            if (mode == 3 && k == 345) begin
                chk("stall_addr", 32'(m_addr), 32'h1FFF);
                chk("stall_req", 32'(m_req), 32'd1);
            end
            if (mode == 5 && k == 100) begin
                frame_active = 1'b0;
                reset = 1'b1;
                #1;
                chk_outputs_zero("async_reset");
                @(posedge clk); #1;
                reset = 1'b0;
                sb.delete();
                repeat (4) begin
                    chk("no_commit_after_reset", 32'(m_commit), 32'd0);
                    chk("idle_after_reset", 32'(m_busy), 32'd0);
                    @(posedge clk); #1;
                end
                return;
            end
            @(posedge clk); #1;
        end
        frame_active = 1'b0;
        start = 1'b0;
        chk("all_writes_seen", 32'(sb.size()), 32'd0);
        repeat (3) begin
            chk("idle_after_frame_busy", 32'(m_busy), 32'd0);
            chk("idle_after_frame_commit", 32'(m_commit), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; gnt = 1'b0; sel6 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_frame(1, 320, 322);
        run_frame(2, 320, 642);
        run_frame(3, 320, 372);
        run_frame(4, 320, 322);
        run_frame(5, 320, 322);
        run_frame(1, 320, 322);

        sel6 = 1'b1;
        @(posedge clk); #1;
        run_frame(1, 10, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
